// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_pkg
// Purpose  : Shared types and default sizes for the FIFO read controller.
//            state_t : controller state (IDLE / ACTIVE / ERR)
//            DEF_*   : default parameter values for the controller and its
//                      interface
// Revision : 1.0 - initial release
// ============================================================================
package fifo_rd_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_READ_LAT   = 1;
  localparam int DEF_SKID_DEPTH = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERR    = 2'd2
  } state_t;

endpackage : fifo_rd_pkg
`default_nettype wire

// File: rtl/fifo_read_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_read_ctrl_if
// Purpose  : Bundles the FIFO read controller's configuration, write-strobe,
//            memory read port, consumer ready/valid and status signals.
// Modports :
//   slave  - the controller: takes clk_en, depth, wen_in, mem_data,
//            mem_valid, out_ready; drives ren_out, out_data, out_valid,
//            occupancy, overflow_err, proto_err
//   master - the environment (core + consumer + host), the mirror image
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_read_ctrl_if
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) ();

  logic              clk_en;
  logic [CNT_W-1:0]  depth;
  logic              wen_in;
  logic              ren_out;
  logic [DATA_W-1:0] mem_data;
  logic              mem_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  occupancy;
  logic              overflow_err;
  logic              proto_err;

  modport slave (
    input  clk_en, depth, wen_in, mem_data, mem_valid, out_ready,
    output ren_out, out_data, out_valid, occupancy, overflow_err, proto_err
  );

  modport master (
    output clk_en, depth, wen_in, mem_data, mem_valid, out_ready,
    input  ren_out, out_data, out_valid, occupancy, overflow_err, proto_err
  );

endinterface : fifo_read_ctrl_if
`default_nettype wire

// File: rtl/fifo_rd_skid.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_skid
// Purpose  : SKID_DEPTH-entry circular buffer that absorbs returning read data.
// Ports    :
//   clk, reset  - clock, synchronous active-high reset
//   push        - write push_data at the tail (caller guarantees not full)
//   push_data   - data to store
//   pop         - advance the head (caller guarantees not empty)
//   head_data   - oldest stored entry
//   count       - number of stored entries
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_skid #(
  parameter int DATA_W     = 16,
  parameter int SKID_DEPTH = 3,
  parameter int COUNT_W    = $clog2(SKID_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [DATA_W-1:0]  push_data,
  input  logic               pop,
  output logic [DATA_W-1:0]  head_data,
  output logic [COUNT_W-1:0] count
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SKID_DEPTH - 1);

  logic [DATA_W-1:0]  mem_q [SKID_DEPTH];
  logic [DATA_W-1:0]  mem_d [SKID_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      // Depth need not be a power of two, so wrap explicitly.
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + COUNT_W'(1);
      2'b01:   count_d = count_q - COUNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule : fifo_rd_skid
`default_nettype wire

// File: rtl/fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_read_ctrl
// Purpose  : Read-side controller for the memory core in FIFO mode. Counts
//            words written but not yet requested, issues ren_out when data
//            exists and the skid buffer has credit, captures returning data
//            after READ_LAT cycles and presents it on a ready/valid port.
// Ports    :
//   clk, reset - clock, synchronous active-high reset
//   bus        - fifo_read_ctrl_if.slave: clk_en, depth, wen_in, ren_out,
//                mem_data, mem_valid, out_data, out_valid, out_ready,
//                occupancy, overflow_err, proto_err
// Options  : FIFO_RD_PROTO_CHECK_EN - check mem_valid against the expected
//            return slot, flag proto_err and enter ERR on a mismatch. When
//            undefined mem_valid is ignored and proto_err stays 0.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_read_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int READ_LAT   = DEF_READ_LAT,
  parameter int SKID_DEPTH = DEF_SKID_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  fifo_read_ctrl_if.slave bus
);

  localparam int SC_W = $clog2(SKID_DEPTH + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    occ_q, occ_d;
  logic [READ_LAT-1:0] infl_q, infl_d, infl_shift;
  logic                ovf_q, ovf_d;
  logic                perr_q, perr_d;

  logic                ren;
  logic                wr_acc;
  logic                wr_rej;
  logic                tail;
  logic                push;
  logic                pop;
  logic                proto_evt;
  logic                credit_ok;
  logic                empty_next;
  logic [SC_W-1:0]     skid_cnt;
  logic [SC_W-1:0]     skid_cnt_next;
  logic [DATA_W-1:0]   skid_head;

  // Issue bits march towards the tail; the tail marks the cycle the core
  // returns data for the read issued READ_LAT enabled cycles earlier.
  if (READ_LAT == 1) begin : g_lat_one
    assign infl_shift = ren;
  end else begin : g_lat_multi
    assign infl_shift = {infl_q[READ_LAT-2:0], ren};
  end

  assign tail   = infl_q[READ_LAT-1];
  assign wr_acc = bus.clk_en && bus.wen_in && (occ_q < bus.depth);
  assign wr_rej = bus.clk_en && bus.wen_in && !(occ_q < bus.depth);
  assign pop    = bus.clk_en && (skid_cnt != '0) && bus.out_ready;

  // Reads already in flight hold a skid slot, so the buffer cannot overflow.
  assign credit_ok = (int'(skid_cnt) + $countones(infl_q)) < SKID_DEPTH;

`ifdef FIFO_RD_PROTO_CHECK_EN
  // Data for reads issued just before a reset may still arrive; the mask
  // hides mem_valid for READ_LAT enabled cycles after reset.
  logic [READ_LAT-1:0] mask_q, mask_d;

  always_comb begin
    mask_d = mask_q;
    if (bus.clk_en) begin
      mask_d = mask_q << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '1;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign push      = bus.clk_en && tail && bus.mem_valid;
  assign proto_evt = bus.clk_en && !(|mask_q) && (bus.mem_valid != tail);
`else
  logic unused_mem_valid;
  assign unused_mem_valid = bus.mem_valid;
  assign push      = bus.clk_en && tail;
  assign proto_evt = 1'b0;
`endif

  fifo_rd_skid #(
    .DATA_W     (DATA_W),
    .SKID_DEPTH (SKID_DEPTH),
    .COUNT_W    (SC_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (bus.mem_data),
    .pop       (pop),
    .head_data (skid_head),
    .count     (skid_cnt)
  );

  // Occupancy, in-flight pipe and sticky flags.
  always_comb begin
    occ_d  = occ_q;
    infl_d = infl_q;
    ovf_d  = ovf_q;
    perr_d = perr_q;
    if (bus.clk_en) begin
      case ({wr_acc, ren})
        2'b10:   occ_d = occ_q + CNT_W'(1);
        2'b01:   occ_d = occ_q - CNT_W'(1);
        default: occ_d = occ_q;
      endcase
      infl_d = infl_shift;
      if (wr_rej) begin
        ovf_d = 1'b1;
      end
      if (proto_evt) begin
        perr_d = 1'b1;
      end
    end
  end

  always_comb begin
    skid_cnt_next = skid_cnt;
    case ({push, pop})
      2'b10:   skid_cnt_next = skid_cnt + SC_W'(1);
      2'b01:   skid_cnt_next = skid_cnt - SC_W'(1);
      default: skid_cnt_next = skid_cnt;
    endcase
  end

  assign empty_next = (occ_d == '0) && (infl_d == '0) && (skid_cnt_next == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q  <= '0;
      infl_q <= '0;
      ovf_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      infl_q <= infl_d;
      ovf_q  <= ovf_d;
      perr_q <= perr_d;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. ACTIVE falls back to IDLE once occupancy, in-flight
  // reads and skid contents will all be empty after this edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wr_acc) state_d = ACTIVE;
      ACTIVE:  if (bus.clk_en && empty_next) state_d = IDLE;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
    if (proto_evt) begin
      state_d = ERR;
    end
  end

  // FSM: outputs. ren depends only on registered state and clk_en.
  always_comb begin
    ren = 1'b0;
    if (bus.clk_en && (occ_q != '0) && credit_ok && (state_q != ERR)) begin
      ren = 1'b1;
    end
  end

  assign bus.ren_out      = ren;
  assign bus.out_data     = skid_head;
  assign bus.out_valid    = (skid_cnt != '0);
  assign bus.occupancy    = occ_q;
  assign bus.overflow_err = ovf_q;
  assign bus.proto_err    = perr_q;

endmodule : fifo_read_ctrl
`default_nettype wire

// File: doc/fifo_read_ctrl.md
# fifo_read_ctrl

Read-side controller for the memory core in FIFO mode. It tracks FIFO occupancy from the write strobes, issues `ren` to the core only when data exists and there is room downstream, and absorbs the core's fixed read latency in a small skid buffer. The buffered data is presented to a downstream ready/valid consumer. It sits between the memory core's read port and the host or checker that drains the FIFO.

## Interface
Parameters:
- `DATA_W`, 16: data width.
- `CNT_W`, 16: occupancy/depth counter width.
- `READ_LAT`, 1: cycles from `ren_out` to `mem_valid`/`mem_data`.
- `SKID_DEPTH`, 3: skid entries. Must be ≥ READ_LAT+2 for full throughput.

Ports (clock `clk`; reset `reset`, synchronous, active-high):
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `clk_en`  in  1  global enable; low freezes all state
- `depth`  in  CNT_W  configured FIFO depth; static after reset
- `wen_in`  in  1  write strobe seen by the core
- `ren_out`  out  1  read request to the core
- `mem_data`  in  DATA_W  core read data
- `mem_valid`  in  1  core read-data valid
- `out_data`  out  DATA_W  head of skid buffer
- `out_valid`  out  1  skid buffer non-empty
- `out_ready`  in  1  consumer accepts `out_data`
- `occupancy`  out  CNT_W  words in the core not yet requested
- `overflow_err`  out  1  sticky; write arrived while occupancy == depth
- `proto_err`  out  1  sticky; core valid/latency mismatch (see Configuration)

## Operation
- State machine in `fifo_rd_pkg::state_t`:
  - IDLE: occupancy 0, nothing in flight, skid empty.
  - ACTIVE: any of occupancy, in flight, or skid contents non-zero.
  - ERR: entered on `proto_err`; held until reset. In ERR, `ren_out` = 0 and the skid still drains.
- Transitions:
  - IDLE→ACTIVE on an accepted write.
  - ACTIVE→IDLE when all three are zero at the clock edge.
- All updates are qualified by `clk_en`. With `clk_en` low, nothing changes and `ren_out` = 0.
- Write accept: `wen_in` && occupancy < depth → occupancy+1. If occupancy == depth, set `overflow_err` and do not count the write.
- Read issue: `ren_out` = clk_en && occupancy > 0 && (skid_count + inflight_count) < SKID_DEPTH && state != ERR. Each issue decrements occupancy.
- Simultaneous accepted write and issue: occupancy unchanged.
- In-flight tracking: a READ_LAT-deep shift register of issue bits; the tail bit marks expected return data.
- Capture: push `mem_data` into the skid on the expected-return cycle.
- Pop: `out_valid` && `out_ready` → head advances, with pointer modulo SKID_DEPTH wrap. Push and pop in the same cycle leave skid_count unchanged.
- Credit rule counts in-flight reads, so the skid never overflows.
- `depth` = 0: no write is accepted; every `wen_in` sets `overflow_err`.

## Timing
- Reset values: `ren_out` 0, `out_valid` 0, `out_data` 0, `occupancy` 0, `overflow_err` 0, `proto_err` 0; state IDLE; pointers and counts 0.
- `ren_out` is combinational from registered state only. There is no path from `wen_in` or `out_ready` to `ren_out`.
- Write at cycle t → occupancy+1 visible at t+1 → `ren_out` at t+1 → `mem_valid` at t+1+READ_LAT → `out_valid` at t+2+READ_LAT. With READ_LAT=1 this is t+3.
- Throughput is one word per cycle while `out_ready` = 1 and SKID_DEPTH ≥ READ_LAT+2.
- Reset mid-operation discards in-flight reads and skid contents. Late `mem_valid` within READ_LAT cycles after reset is ignored, not flagged.

## Configuration
- `FIFO_RD_PROTO_CHECK_EN` defined:
  - `proto_err` is set when `mem_valid` is high with tail bit 0, or tail bit 1 with `mem_valid` low (with `clk_en` high).
  - The ERR state exists.
  - Capture requires tail bit && `mem_valid`.
- Undefined:
  - `mem_valid` is ignored and `proto_err` is tied 0.
  - Capture uses the tail bit alone.
  - The ERR state is never entered.

## Structure
- Package `fifo_rd_pkg`: `state_t` enum (IDLE, ACTIVE, ERR) and default width constants.
- Sub-module `fifo_rd_skid`: SKID_DEPTH circular buffer with push/pop, count, head data. It is instantiated once.
- Top holds the FSM, occupancy counter, in-flight shift register, and error flags.

## Test plan
- depth=4; write 0x0011, 0x0022, 0x0033 on consecutive cycles; `out_ready`=1 → `out_data` 0x0011/0x0022/0x0033 on cycles t+3..t+5; occupancy returns to 0; state back to IDLE.
- depth=2; 3 writes with `out_ready`=0 → occupancy peaks at 2 or less. The third write sets `overflow_err` only if occupancy==2 at that cycle. Skid fills to 3 or less; `ren_out` stops when skid+inflight=3.
- Steady stream of 8 writes, `out_ready` toggling 1,0,1,0 → all 8 words delivered in order; no skid overflow; no drop.
- `clk_en` low for 3 cycles mid-stream → `ren_out`=0, all counters frozen; stream resumes unchanged.
- Macro on: force `mem_valid`=1 with no read issued → `proto_err`=1 next cycle; `ren_out` held 0 until reset.
- Reset asserted with 2 reads in flight and 1 word in skid → all outputs 0 the next cycle; a stray `mem_valid` one cycle later produces no `out_valid` and no `proto_err`.
